// File: rtl/flasher_pkg.sv
// Shared types and defaults for the bound_flasher stimulus sequencer.
// Holds the sequencer state encoding and lamp bar width.
package flasher_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        WAIT_DARK
    } seq_state_t;

    localparam int LAMP_W    = 16;
    localparam int CNT_W_DEF = 8;
    localparam int DEPTH_DEF = 4;

endpackage

// File: rtl/seq_cmd_fifo.sv
// Synchronous command FIFO with occupancy count and flush.
// Head entry is presented combinationally on dout.
module seq_cmd_fifo #(
    parameter  int W     = 9,
    parameter  int DEPTH = 4,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  din,
    output logic [W-1:0]  dout,
    output logic [CW-1:0] count
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign do_push = push && (count != CW'(DEPTH));
    assign do_pop  = pop && (count != '0);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)
                count <= count + 1'b1;
            else if (!do_push && do_pop)
                count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/flick_sequencer.sv
// Queued (level, duration) command player driving flick for bound_flasher.
// Duration 0 holds the level until the lamp bar has gone dark.
module flick_sequencer
    import flasher_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_level,
    input  logic [CNT_W-1:0]  cmd_cycles,
    input  logic              abort,
    input  logic [LAMP_W-1:0] lamp,
    output logic              flick,
    output logic              busy,
    output logic              done
);

    localparam int CW = $clog2(DEPTH + 1);

    seq_state_t       state;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W:0]   head;
    logic [CW-1:0]    count;
    logic             head_level;
    logic [CNT_W-1:0] head_cycles;
    logic             push;
    logic             load;
    logic             step_done;

    assign cmd_ready   = (count != CW'(DEPTH));
    assign push        = cmd_valid && cmd_ready && !abort;
    assign head_level  = head[CNT_W];
    assign head_cycles = head[CNT_W-1:0];
    assign busy        = (state != IDLE) || (count != '0);

    seq_cmd_fifo #(
        .W     (CNT_W + 1),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (load),
        .flush (abort),
        .din   ({cmd_level, cmd_cycles}),
        .dout  (head),
        .count (count)
    );

    always_comb begin
        step_done = 1'b0;
        unique case (state)
            DRIVE:     step_done = (remaining == '0);
            WAIT_DARK: step_done = (lamp == '0);
            default:   step_done = 1'b0;
        endcase
    end

    // Chaining on step completion keeps back-to-back steps gap-free.
    assign load = !abort && (count != '0)
                  && ((state == IDLE) || step_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            remaining <= '0;
            flick     <= 1'b0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            if (abort) begin
                state     <= IDLE;
                remaining <= '0;
                flick     <= 1'b0;
            end else if (load) begin
                flick <= head_level;
                if (head_cycles != '0) begin
                    state     <= DRIVE;
                    remaining <= head_cycles - 1'b1;
                end else begin
                    state     <= WAIT_DARK;
                    remaining <= '0;
                end
            end else if (step_done) begin
                state <= IDLE;
                flick <= 1'b0;
                done  <= 1'b1;
            end else if (state == DRIVE) begin
                remaining <= remaining - 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_flick_sequencer.sv
// Bench for flick_sequencer: timeline reference model with per-edge scoreboard.
// Stimulus schedules expected outputs by edge number; a monitor compares them.
module tb_flick_sequencer;
    import flasher_pkg::*;

    localparam int DEPTH = 4;
    localparam int CNT_W = 8;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              cmd_valid = 1'b0;
    logic              cmd_level = 1'b0;
    logic [CNT_W-1:0]  cmd_cycles = '0;
    logic              abort = 1'b0;
    logic [LAMP_W-1:0] lamp = '0;
    logic              cmd_ready;
    logic              flick;
    logic              busy;
    logic              done;

    int checks = 0;
    int errors = 0;
    int edge_n = 0;
    int last_end = 0;
    int dark_from = 0;
    bit mon_en = 1'b0;

    bit exp_flick [int];
    bit exp_busy [int];
    bit exp_done [int];
    int pend [$];

    flick_sequencer #(
        .CNT_W (CNT_W),
        .DEPTH (DEPTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_level  (cmd_level),
        .cmd_cycles (cmd_cycles),
        .abort      (abort),
        .lamp       (lamp),
        .flick      (flick),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s at edge %0d: got %0d required %0d",
                         nm, edge_n, act, req);
        end
    endtask

    // A step starts right after the previous one ends if it was queued
    // before that end, otherwise on the edge after it is accepted.
    task automatic model_push(input int k, input bit lvl, input int cy);
        int s;
        int e;
        if (k < last_end) begin
            s = last_end;
            exp_done.delete(last_end);
        end else begin
            s = k + 1;
        end
        if (cy == 0)
            e = (s + 1 >= dark_from) ? s + 1 : dark_from;
        else
            e = s + cy;
        for (int t = s; t < e; t++) exp_flick[t] = lvl;
        for (int t = k; t < e; t++) exp_busy[t] = 1'b1;
        exp_done[e] = 1'b1;
        last_end = e;
        pend.push_back(s);
    endtask

    task automatic model_abort(input int k);
        for (int t = k; t <= last_end; t++) begin
            exp_flick.delete(t);
            exp_busy.delete(t);
            exp_done.delete(t);
        end
        pend.delete();
        last_end = k;
    endtask

    task automatic drive(input bit v, input bit lvl, input int cy,
                         input bit ab, output bit acc);
        int k;
        bit rdy;
        @(negedge clk);
        k = edge_n + 1;
        while (pend.size() > 0 && pend[0] < k)
            void'(pend.pop_front());
        rdy = (pend.size() != DEPTH);
        check("cmd_ready", 32'(cmd_ready), 32'(rdy));
        cmd_valid  = v;
        cmd_level  = lvl;
        cmd_cycles = CNT_W'(cy);
        abort      = ab;
        lamp = (k < dark_from) ? LAMP_W'($urandom_range(1, 65535)) : '0;
        acc = v && rdy && !ab;
        if (ab)
            model_abort(k);
        else if (acc)
            model_push(k, lvl, cy);
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) drive(1'b0, 1'b0, 0, 1'b0, acc);
    endtask

    task automatic send(input bit lvl, input int cy);
        bit acc;
        int tries;
        tries = 0;
        acc = 1'b0;
        while (!acc && tries < 600) begin
            drive(1'b1, lvl, cy, 1'b0, acc);
            tries++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout at edge %0d: got %0d required %0d",
                     edge_n, 0, 1);
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (edge_n < last_end + 1 && n < 2000) begin
            idle(1);
            n++;
        end
        if (edge_n < last_end + 1) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout at edge %0d: got %0d required %0d",
                     edge_n, edge_n, last_end + 1);
        end
        idle(2);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            edge_n++;
            #1;
            if (mon_en) begin
                check("flick", 32'(flick), 32'(exp_flick.exists(edge_n)
                      ? exp_flick[edge_n] : 1'b0));
                check("busy", 32'(busy), 32'(exp_busy.exists(edge_n)
                      ? exp_busy[edge_n] : 1'b0));
                check("done", 32'(done), 32'(exp_done.exists(edge_n)
                      ? exp_done[edge_n] : 1'b0));
                exp_flick.delete(edge_n);
                exp_busy.delete(edge_n);
                exp_done.delete(edge_n);
            end
        end
    end

    initial begin
        bit acc;
        int r;
        int cy;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_flick", 32'(flick), 32'd0);
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset  = 1'b0;
        mon_en = 1'b1;
        idle(2);

        send(1'b1, 5);
        wait_idle();

        send(1'b1, 3);
        send(1'b0, 2);
        send(1'b1, 4);
        wait_idle();

        send(1'b1, 20);
        for (int i = 0; i < 4; i++) send(1'b0, 1);
        drive(1'b1, 1'b0, 1, 1'b0, acc);
        send(1'b1, 2);
        wait_idle();

        dark_from = edge_n + 10;
        send(1'b1, 0);
        wait_idle();
        dark_from = 0;

        send(1'b1, 10);
        send(1'b0, 3);
        send(1'b1, 3);
        idle(3);
        drive(1'b1, 1'b1, 7, 1'b1, acc);
        idle(3);
        wait_idle();

        send(1'b1, 255);
        wait_idle();

        for (int i = 0; i < 800; i++) begin
            r = $urandom_range(0, 63);
            if (r == 0)
                cy = 0;
            else if (r == 1)
                cy = 255;
            else
                cy = $urandom_range(1, 6);
            drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), cy,
                  ($urandom_range(0, 59) == 0), acc);
        end
        wait_idle();

        send(1'b1, 30);
        idle(5);
        @(posedge clk);
        #2;
        mon_en = 1'b0;
        reset  = 1'b1;
        #1;
        check("arst_flick", 32'(flick), 32'd0);
        check("arst_busy", 32'(busy), 32'd0);
        check("arst_done", 32'(done), 32'd0);
        check("arst_ready", 32'(cmd_ready), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
